// File: rtl/pipe_adder.sv
// Segmented carry-pipelined adder/subtractor. Each stage adds SEG bits and
// registers the carry for the next stage. The whole pipe stalls on output back-pressure.
module pipe_adder #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG;
   localparam int LAST   = STAGES - 1;

   if (WIDTH % SEG != 0) begin : g_bad_seg
      $error("pipe_adder: WIDTH must be a multiple of SEG");
   end

   // Per-stage inputs. Operands travel full width and unused low bits are
   // trimmed in synthesis. Partial sums accumulate one segment per stage.
   logic [WIDTH-1:0] w_ai [STAGES];
   logic [WIDTH-1:0] w_bi [STAGES];
   logic [WIDTH-1:0] w_si [STAGES];
   logic [WIDTH-1:0] w_so [STAGES];
   logic             w_ci [STAGES];
   logic             w_vi [STAGES];
   logic [SEG:0]     w_seg [STAGES];
   logic             w_stall;

   logic [WIDTH-1:0] r_a  [STAGES];
   logic [WIDTH-1:0] r_b  [STAGES];
   logic [WIDTH-1:0] r_s  [STAGES];
   logic             r_cy [STAGES];
   logic             r_vld [STAGES];

   assign w_stall  = r_vld[LAST] & ~out_ready;
   assign in_ready = ~w_stall;

   // NOTE: every always_comb output gets a value on every path, so no latches.
   always_comb begin
      w_ai[0] = a;
      w_bi[0] = sub ? ~b : b;
      w_si[0] = '0;
      w_ci[0] = cin ^ sub;
      w_vi[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_ai[k] = r_a[k-1];
         w_bi[k] = r_b[k-1];
         w_si[k] = r_s[k-1];
         w_ci[k] = r_cy[k-1];
         w_vi[k] = r_vld[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_seg[k] = {1'b0, w_ai[k][k*SEG +: SEG]} + {1'b0, w_bi[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, w_ci[k]};
         w_so[k]  = w_si[k];
         w_so[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
      end
   end

   // NOTE: data registers are reset as well as valids, so outputs read zero in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_s[k]   <= '0;
            r_cy[k]  <= 1'b0;
         end
      end else if (!w_stall) begin
         // NOTE: non-blocking assignments let each stage read last cycle's neighbour.
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= w_vi[k];
            // Bubbles leave data untouched, so the output holds the last result.
            if (w_vi[k]) begin
               r_a[k]  <= w_ai[k];
               r_b[k]  <= w_bi[k];
               r_s[k]  <= w_so[k];
               r_cy[k] <= w_seg[k][SEG];
            end
         end
      end
   end

   assign out_valid = r_vld[LAST];
   assign sum       = r_s[LAST];
   assign cout      = r_cy[LAST];
   // The carry into the MSB is a^b^sum at that bit. ovf is that carry XOR the carry out.
   assign ovf       = r_a[LAST][WIDTH-1] ^ r_b[LAST][WIDTH-1] ^ r_s[LAST][WIDTH-1] ^ r_cy[LAST];

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 The block SHALL have parameter SEG, default 4, bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG, and STAGES = WIDTH/SEG.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, operands present this cycle.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, operands.
REQ-008 The block SHALL have port cin, input, 1, carry-in for add, borrow-in for subtract.
REQ-009 The block SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-010 The block SHALL have port out_valid, output, 1, result present.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 The block SHALL have port sum, output, WIDTH, result.
REQ-013 The block SHALL have port cout, output, 1, carry out of the MSB.
REQ-014 The block SHALL have port ovf, output, 1, signed overflow.

Function
REQ-015 Arithmetic SHALL be defined as follows: add gives {cout,sum} = a + b + cin; subtract gives {cout,sum} = a + ~b + ~cin, i.e. a - b - cin, where cout=1 means no borrow.
REQ-016 ovf SHALL equal carry into the MSB XOR carry out of the MSB, applying to both modes.
REQ-017 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-018 Pipeline structure: stage k (k=0..STAGES-1) SHALL add segment k, bits [k*SEG +: SEG], using the carry registered by stage k-1; stage 0 SHALL use the effective carry-in.
REQ-019 Pipeline structure: upper operand segments SHALL be delayed, and completed lower sum segments SHALL be skewed forward, so that each result emerges aligned.
REQ-020 Latency SHALL be STAGES cycles: operands accepted at edge n SHALL produce out_valid=1 with the matching result after edge n+STAGES, provided no stall occurs.
REQ-021 Throughput SHALL be one operation per cycle with no bubbles while out_ready=1.
REQ-022 A valid bit SHALL travel with each stage; an empty stage SHALL not affect results.
REQ-023 Stall: when out_valid=1 and out_ready=0, every stage SHALL hold its contents; in_ready SHALL be 0 that cycle.
REQ-024 in_ready SHALL be 0 only during a stall; it SHALL be combinational from out_valid and out_ready.
REQ-025 sum, cout and ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 When out_valid=0, the values of sum, cout and ovf SHALL be don't-care but deterministic; they SHALL hold the last result.
REQ-027 Operations SHALL retire in acceptance order; no operation SHALL be dropped or duplicated.
REQ-028 sub and cin SHALL be captured per operation, so mixed add/sub streams are legal.
REQ-029 Case SEG=WIDTH: the block SHALL have a latency of 1 and remain correct.

Reset
REQ-030 While rst=1, all valid bits, sum, cout and ovf SHALL be 0 immediately, regardless of clk.
REQ-031 in_ready SHALL be 1 during and after reset.
REQ-032 A reset mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear afterwards.
REQ-033 The first operand accepted after rst falls SHALL appear after exactly STAGES edges.

Verification (WIDTH=16, SEG=4, latency 4)
REQ-034 Reset scenario: assert rst mid-cycle -> out_valid=0, sum=0x0000, cout=0, ovf=0 before next edge; in_ready=1.
REQ-035 Add-with-wrap scenario: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 edges later sum=0x0000, cout=1, ovf=0.
REQ-036 Signed-overflow scenario: add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1; sub 0x8000-0x0001, cin=0 -> sum=0x7FFF, cout=1, ovf=1; sub 0x0000-0x0001 -> sum=0xFFFF, cout=0, ovf=0.
REQ-037 Stall scenario: stream 8 back-to-back random ops, drop out_ready for 3 cycles mid-stream -> in_ready=0 during those cycles, output held stable, all 8 results correct and in order against a reference model.
REQ-038 Reset-in-flight scenario: accept 3 ops, assert rst for 1 cycle -> out_valid stays 0 for the next 4 cycles with no stale result; a new op then emerges after exactly 4 edges.
REQ-039 Random scenario: 10k random ops with random in_valid, out_ready, sub and cin -> every output matches a + b + cin or a - b - cin with correct cout and ovf; also rerun with SEG=16.
